systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Synthesizable successor to the hand-written skewed stimulus sequencer that drives the 8x8 PE cluster.
- Holds per-row activation and weight vectors in an internal buffer, then streams them into a ROWS-wide systolic array.
- Row r is delayed r ticks in skew mode, or not delayed in aligned mode, and each row's done flag is raised after its last element.
- Sits between the host/load logic and the pe cluster activations/weights/done inputs.

Parameters:
- ROWS, 8: number of array rows/lanes.
- DATA_W, 16: element width of activations and weights.
- K_MAX, 16: maximum elements per row, which is the buffer depth per row.
- KW, $clog2(K_MAX+1): width of the k_len field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable; 0 freezes sequencing.
- ld_en  in  1  buffer write strobe.
- ld_row  in  $clog2(ROWS)  buffer write row.
- ld_idx  in  $clog2(K_MAX)  buffer write element index.
- ld_act  in  DATA_W  activation write data.
- ld_wgt  in  DATA_W  weight write data.
- start  in  1  begin a feed pass.
- k_len  in  KW  elements per row for this pass, sampled on start.
- skew_en  in  1  1 = diagonal skew, 0 = all rows aligned; sampled on start.
- activations  out  ROWS*DATA_W  row r occupies [r*DATA_W +: DATA_W].
- weights  out  ROWS*DATA_W  same packing as activations.
- done  out  ROWS  sticky per-row done.
- busy  out  1  high in FEED.
- complete  out  1  one-cycle pulse at end of pass.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0. Buffer contents are not cleared. Reset mid-pass aborts the pass with no complete pulse.
- States are IDLE and FEED. All outputs are registered.
- IDLE:
  - ld_en writes buffer[ld_row][ld_idx] on the same edge.
  - ld_en in FEED is dropped; the buffer is unchanged.
- Start acceptance (IDLE, en=1, start=1):
  - If 1<=k_len<=K_MAX: latch k_len as K and skew_en as S; clear done to 0; set t=0; enter FEED; busy=1 from the next cycle.
  - If k_len==0 or k_len>K_MAX: stay IDLE and pulse cfg_err for one cycle.
  - start in FEED, or with en=0, is ignored with no error.
- FEED, each edge with en=1, for tick t:
  - Row delay is d(r) = S ? r : 0.
  - If d(r) <= t < d(r)+K: row r outputs buffer[r][t-d(r)] on both activations and weights. Otherwise row r outputs 0.
  - If t == d(r)+K: done[r] is set. It stays set until the next accepted start or rst.
  - t increments each tick.
- End of pass:
  - The last tick is T_END = K + (S ? ROWS-1 : 0).
  - At T_END, all still-unset done bits are set, complete pulses, and state returns to IDLE.
  - On the following edge the data outputs return to 0 and busy=0.
- Latency and length:
  - Row 0 element 0 is visible on the cycle after the start edge.
  - A pass occupies T_END+1 enabled cycles.
- en=0 in FEED: t, outputs, done and busy hold their values. Sequencing resumes exactly where it stopped.
- Simultaneous rst and start: rst wins.

Decomposition:
- Shared header systolic_defs.vh holds:
  - ROWS, DATA_W and K_MAX defaults.
  - State encodings IDLE=0, FEED=1.
  - Lane slice macro [r*DATA_W +: DATA_W].
- Sub-module feed_buffer: ROWS x K_MAX dual-array (act/wgt) storage with one write port and ROWS parallel combinational read ports, indexed by per-row element address.
- The feeder holds the FSM, tick counter, per-row index computation, and output/done registers.

Test Plan:
- Skew pass: load row r element i with act=r*4+i+1 and wgt=0x100+r*4+i, then start with k_len=4, skew_en=1 -> row0 outputs 1,2,3,4 on cycles 1-4. Row7 outputs 29..32 on cycles 8-11. done[0] sets at tick 4 and done[7] at tick 11. complete pulses at tick 11. busy falls after tick 11.
- Aligned pass: same buffer, skew_en=0, k_len=4 -> all rows output their element i on the same cycle i+1. done is 0xFF and complete pulses at tick 4.
- Bad length: start with k_len=0, then start with k_len=K_MAX+1 -> cfg_err pulses once each. busy stays 0 and done is unchanged.
- Stall: deassert en for 3 cycles at tick 5 of the skew pass -> outputs and done are frozen for those cycles. The remaining sequence is identical, shifted by 3 cycles.
- Load during FEED plus restart: issue ld_en with row0 idx0 data 0xDEAD mid-pass -> the second pass still outputs 1 first. A start during FEED has no effect.
- Reset mid-pass: assert rst at tick 6 -> the next cycle shows all outputs 0, IDLE, and no complete pulse. A new start replays the original buffer data.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared defaults, FSM state encoding and lane slicing helper for the skewed feeder.
// Imported by the feeder top and available to anything driving the PE cluster.
package systolic_skew_feeder_pkg;

    localparam int DEF_ROWS   = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_K_MAX  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } feed_state_e;

    // Low bit of lane r inside a packed ROWS*w output bus
    function automatic int lane_lo(input int r, input int w);
        return r * w;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_feed_buffer.sv
// Per-row activation/weight storage: one write port, one combinational read port per row.
// Contents are deliberately not reset so a pass can be replayed after rst.
module systolic_skew_feeder_feed_buffer #(
    parameter int ROWS   = 8,
    parameter int DATA_W = 16,
    parameter int K_MAX  = 16
) (
    input  logic                               clk,
    input  logic                               wr_en,
    input  logic [$clog2(ROWS)-1:0]            wr_row,
    input  logic [$clog2(K_MAX)-1:0]           wr_idx,
    input  logic [DATA_W-1:0]                  wr_act,
    input  logic [DATA_W-1:0]                  wr_wgt,
    input  logic [ROWS-1:0][$clog2(K_MAX)-1:0] rd_idx,
    output logic [ROWS-1:0][DATA_W-1:0]        rd_act,
    output logic [ROWS-1:0][DATA_W-1:0]        rd_wgt
);

    logic [DATA_W-1:0] act_mem [ROWS][K_MAX];
    logic [DATA_W-1:0] wgt_mem [ROWS][K_MAX];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            act_mem[wr_row][wr_idx] <= wr_act;
            wgt_mem[wr_row][wr_idx] <= wr_wgt;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            rd_act[r] = act_mem[r][rd_idx[r]];
            rd_wgt[r] = wgt_mem[r][rd_idx[r]];
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Streams buffered per-row vectors into a ROWS-wide systolic array, optionally
// skewing row r by r ticks, with sticky per-row done flags and a completion pulse.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int K_MAX  = DEF_K_MAX,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     ld_en,
    input  logic [$clog2(ROWS)-1:0]  ld_row,
    input  logic [$clog2(K_MAX)-1:0] ld_idx,
    input  logic [DATA_W-1:0]        ld_act,
    input  logic [DATA_W-1:0]        ld_wgt,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    input  logic                     skew_en,
    output logic [ROWS*DATA_W-1:0]   activations,
    output logic [ROWS*DATA_W-1:0]   weights,
    output logic [ROWS-1:0]          done,
    output logic                     busy,
    output logic                     complete,
    output logic                     cfg_err
);

    localparam int IW = $clog2(K_MAX);
    localparam int TW = $clog2(K_MAX + ROWS);

    feed_state_e state, state_nx;

    logic [TW-1:0] tick, tick_nx;
    logic [KW-1:0] k_q;
    logic          skew_q;
    logic [TW-1:0] t_end;
    logic          len_ok, accept, reject, last_tick;

    logic [ROWS-1:0][TW-1:0]     row_dly;
    logic [ROWS-1:0]             row_live;
    logic [ROWS-1:0]             row_hit;
    logic [ROWS-1:0][IW-1:0]     rd_idx;
    logic [ROWS-1:0][DATA_W-1:0] rd_act;
    logic [ROWS-1:0][DATA_W-1:0] rd_wgt;

    logic [ROWS*DATA_W-1:0] act_nx, wgt_nx;
    logic [ROWS-1:0]        done_nx;
    logic                   busy_nx, complete_nx, cfg_err_nx;

    // The buffer is only writable between passes so a running pass sees stable data
    systolic_skew_feeder_feed_buffer #(
        .ROWS   (ROWS),
        .DATA_W (DATA_W),
        .K_MAX  (K_MAX)
    ) u_buffer (
        .clk    (clk),
        .wr_en  (ld_en && (state == IDLE)),
        .wr_row (ld_row),
        .wr_idx (ld_idx),
        .wr_act (ld_act),
        .wr_wgt (ld_wgt),
        .rd_idx (rd_idx),
        .rd_act (rd_act),
        .rd_wgt (rd_wgt)
    );

    assign len_ok    = (k_len != '0) && (k_len <= KW'(K_MAX));
    assign accept    = (state == IDLE) && en && start && len_ok;
    assign reject    = (state == IDLE) && en && start && !len_ok;
    assign t_end     = TW'(k_q) + (skew_q ? TW'(ROWS - 1) : '0);
    assign last_tick = (state == FEED) && en && (tick == t_end);

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_dly[r]  = skew_q ? TW'(r) : '0;
            row_live[r] = (tick >= row_dly[r]) && (tick < row_dly[r] + TW'(k_q));
            row_hit[r]  = (tick == row_dly[r] + TW'(k_q));
            rd_idx[r]   = IW'(tick - row_dly[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FEED;
            FEED:    if (last_tick) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of every registered output; en=0 in FEED simply holds them
    always_comb begin
        act_nx      = activations;
        wgt_nx      = weights;
        done_nx     = done;
        busy_nx     = busy;
        tick_nx     = tick;
        complete_nx = 1'b0;
        cfg_err_nx  = reject;
        case (state)
            IDLE: begin
                act_nx  = '0;
                wgt_nx  = '0;
                busy_nx = accept;
                if (accept) begin
                    done_nx = '0;
                    tick_nx = '0;
                end
            end
            FEED: begin
                busy_nx = 1'b1;
                if (en) begin
                    for (int r = 0; r < ROWS; r++) begin
                        act_nx[lane_lo(r, DATA_W) +: DATA_W] = row_live[r] ? rd_act[r] : '0;
                        wgt_nx[lane_lo(r, DATA_W) +: DATA_W] = row_live[r] ? rd_wgt[r] : '0;
                        done_nx[r] = done[r] | row_hit[r] | last_tick;
                    end
                    tick_nx     = last_tick ? '0 : tick + 1'b1;
                    complete_nx = last_tick;
                end
            end
            default: begin
                act_nx  = '0;
                wgt_nx  = '0;
                busy_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= '0;
            k_q         <= '0;
            skew_q      <= 1'b0;
            activations <= '0;
            weights     <= '0;
            done        <= '0;
            busy        <= 1'b0;
            complete    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            if (accept) begin
                k_q    <= k_len;
                skew_q <= skew_en;
            end
            tick        <= tick_nx;
            activations <= act_nx;
            weights     <= wgt_nx;
            done        <= done_nx;
            busy        <= busy_nx;
            complete    <= complete_nx;
            cfg_err     <= cfg_err_nx;
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized self-checking bench for systolic_skew_feeder against a per-pass
// frame table computed from the buffer contents and the skew/length rules.
module tb_systolic_skew_feeder;

    localparam int ROWS   = 8;
    localparam int DATA_W = 16;
    localparam int K_MAX  = 16;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int NF     = K_MAX + ROWS;

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic                     ld_en;
    logic [$clog2(ROWS)-1:0]  ld_row;
    logic [$clog2(K_MAX)-1:0] ld_idx;
    logic [DATA_W-1:0]        ld_act;
    logic [DATA_W-1:0]        ld_wgt;
    logic                     start;
    logic [KW-1:0]            k_len;
    logic                     skew_en;
    logic [ROWS*DATA_W-1:0]   activations;
    logic [ROWS*DATA_W-1:0]   weights;
    logic [ROWS-1:0]          done;
    logic                     busy;
    logic                     complete;
    logic                     cfg_err;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem_act [ROWS][K_MAX];
    logic [DATA_W-1:0] mem_wgt [ROWS][K_MAX];

    systolic_skew_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ld_en       (ld_en),
        .ld_row      (ld_row),
        .ld_idx      (ld_idx),
        .ld_act      (ld_act),
        .ld_wgt      (ld_wgt),
        .start       (start),
        .k_len       (k_len),
        .skew_en     (skew_en),
        .activations (activations),
        .weights     (weights),
        .done        (done),
        .busy        (busy),
        .complete    (complete),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock edge; outputs are then sampled 1ns later
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic loadElem(input int r, input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] w);
        ld_en  = 1'b1;
        ld_row = ($clog2(ROWS))'(r);
        ld_idx = ($clog2(K_MAX))'(i);
        ld_act = a;
        ld_wgt = w;
        applyStimulus();
        ld_en = 1'b0;
        mem_act[r][i] = a;
        mem_wgt[r][i] = w;
    endtask

    task automatic runPass(input int k, input bit s, input int stall_at, input bit rand_stall,
                           input bit noisy, input int abort_at);
        logic [ROWS*DATA_W-1:0] f_act [NF];
        logic [ROWS*DATA_W-1:0] f_wgt [NF];
        logic [ROWS-1:0]        f_done [NF];
        logic [ROWS*DATA_W-1:0] h_act, h_wgt;
        logic [ROWS-1:0]        h_done;
        logic                   exp_cmp;
        int t_end, d, idx, stalls, guard;

        // Expected frame for every tick of the pass
        t_end = k + (s ? ROWS - 1 : 0);
        for (int t = 0; t <= t_end; t++) begin
            f_act[t]  = '0;
            f_wgt[t]  = '0;
            f_done[t] = '0;
            for (int r = 0; r < ROWS; r++) begin
                d = s ? r : 0;
                if (t >= d && t < d + k) begin
                    f_act[t][r*DATA_W +: DATA_W] = mem_act[r][t-d];
                    f_wgt[t][r*DATA_W +: DATA_W] = mem_wgt[r][t-d];
                end
                if (t >= d + k || t == t_end) f_done[t][r] = 1'b1;
            end
        end

        en      = 1'b1;
        start   = 1'b1;
        k_len   = KW'(k);
        skew_en = s;
        applyStimulus();
        start = 1'b0;
        checkOutput("start_busy", busy, 1'b1);
        checkOutput("start_done", done, '0);
        checkOutput("start_act", activations, '0);

        h_act  = '0;
        h_wgt  = '0;
        h_done = '0;
        idx    = 0;
        stalls = 0;
        guard  = 0;
        while (idx <= t_end && guard < 400 && idx != abort_at) begin
            guard++;
            en = 1'b1;
            if (idx == stall_at && stalls < 3) begin
                en = 1'b0;
                stalls++;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                en = 1'b0;
            end
            if (noisy) begin
                ld_en   = 1'b1;
                ld_row  = '0;
                ld_idx  = '0;
                ld_act  = 16'hDEAD;
                ld_wgt  = 16'hDEAD;
                start   = 1'($urandom_range(0, 1));
                k_len   = KW'($urandom_range(0, 31));
                skew_en = 1'($urandom_range(0, 1));
            end
            applyStimulus();
            ld_en   = 1'b0;
            start   = 1'b0;
            exp_cmp = 1'b0;
            if (en) begin
                h_act   = f_act[idx];
                h_wgt   = f_wgt[idx];
                h_done  = f_done[idx];
                exp_cmp = (idx == t_end);
                idx++;
            end
            checkOutput("feed_act", activations, h_act);
            checkOutput("feed_wgt", weights, h_wgt);
            checkOutput("feed_done", done, h_done);
            checkOutput("feed_busy", busy, 1'b1);
            checkOutput("feed_complete", complete, exp_cmp);
            checkOutput("feed_cfg_err", cfg_err, 1'b0);
        end
        en = 1'b1;

        if (guard >= 400) begin
            checks++;
            failures++;
            $display("[TB] FAIL feed_timeout observed=%0d expected=%0d", idx, t_end + 1);
        end else if (idx == abort_at) begin
            rst = 1'b1;
            applyStimulus();
            rst = 1'b0;
            checkOutput("abort_act", activations, '0);
            checkOutput("abort_wgt", weights, '0);
            checkOutput("abort_done", done, '0);
            checkOutput("abort_busy", busy, 1'b0);
            checkOutput("abort_complete", complete, 1'b0);
            applyStimulus();
            checkOutput("abort_after_complete", complete, 1'b0);
            checkOutput("abort_after_busy", busy, 1'b0);
        end else begin
            applyStimulus();
            checkOutput("end_act", activations, '0);
            checkOutput("end_busy", busy, 1'b0);
            checkOutput("end_complete", complete, 1'b0);
            checkOutput("end_done", done, {ROWS{1'b1}});
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        ld_en   = 1'b0;
        ld_row  = '0;
        ld_idx  = '0;
        ld_act  = '0;
        ld_wgt  = '0;
        start   = 1'b0;
        k_len   = '0;
        skew_en = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_act", activations, '0);
        checkOutput("reset_wgt", weights, '0);
        checkOutput("reset_done", done, '0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_complete", complete, 1'b0);
        checkOutput("reset_cfg_err", cfg_err, 1'b0);
        rst = 1'b0;

        // Random fill, then the known pattern in the first four elements of each row
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < K_MAX; i++)
                loadElem(r, i, DATA_W'($urandom), DATA_W'($urandom));
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < 4; i++)
                loadElem(r, i, DATA_W'(r*4 + i + 1), DATA_W'(16'h100 + r*4 + i));

        runPass(4, 1'b1, -1, 1'b0, 1'b0, -1);
        runPass(4, 1'b0, -1, 1'b0, 1'b0, -1);

        en    = 1'b1;
        start = 1'b1;
        k_len = '0;
        applyStimulus();
        start = 1'b0;
        checkOutput("bad0_cfg_err", cfg_err, 1'b1);
        checkOutput("bad0_busy", busy, 1'b0);
        checkOutput("bad0_done", done, {ROWS{1'b1}});
        applyStimulus();
        checkOutput("bad0_pulse_end", cfg_err, 1'b0);
        start = 1'b1;
        k_len = KW'(K_MAX + 1);
        applyStimulus();
        start = 1'b0;
        checkOutput("bad17_cfg_err", cfg_err, 1'b1);
        checkOutput("bad17_busy", busy, 1'b0);
        checkOutput("bad17_done", done, {ROWS{1'b1}});
        applyStimulus();
        checkOutput("bad17_pulse_end", cfg_err, 1'b0);
        en    = 1'b0;
        start = 1'b1;
        k_len = '0;
        applyStimulus();
        start = 1'b0;
        en    = 1'b1;
        checkOutput("bad_en0_cfg_err", cfg_err, 1'b0);
        checkOutput("bad_en0_busy", busy, 1'b0);

        runPass(4, 1'b1, 5, 1'b0, 1'b1, -1);
        runPass(4, 1'b1, -1, 1'b0, 1'b0, -1);

        runPass(4, 1'b1, -1, 1'b0, 1'b0, 6);
        runPass(4, 1'b1, -1, 1'b0, 1'b0, -1);

        rst   = 1'b1;
        start = 1'b1;
        k_len = KW'(4);
        applyStimulus();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rst_start_busy", busy, 1'b0);
        checkOutput("rst_start_done", done, '0);
        applyStimulus();
        checkOutput("rst_start_after_busy", busy, 1'b0);

        runPass(K_MAX, 1'b1, -1, 1'b1, 1'b0, -1);
        runPass(1, 1'b0, -1, 1'b0, 1'b0, -1);
        runPass(1, 1'b1, -1, 1'b1, 1'b1, -1);

        for (int p = 0; p < 6; p++) begin
            for (int n = 0; n < 4; n++)
                loadElem(int'($urandom_range(0, ROWS-1)), int'($urandom_range(0, K_MAX-1)),
                         DATA_W'($urandom), DATA_W'($urandom));
            runPass(int'($urandom_range(1, K_MAX)), 1'($urandom_range(0, 1)), -1, 1'b1,
                    1'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
